// File: rtl/cpu_pkg.sv
// Shared CPU encodings: write-back source, destination select and
// architecturally significant register indices.
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LUI  = 2'b10,
        WB_LINK = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_RA   = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_mux.sv
// Write-back source mux and destination register resolution (purely combinational).
module wb_mux
    import cpu_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [1:0]      wb_sel,
    input  logic [1:0]      dst_sel,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [size-1:0] alu_result,
    input  logic [size-1:0] mem_data,
    input  logic [size-1:0] lui_result,
    input  logic [size-1:0] pc_plus4,
    output logic [size-1:0] wb_data,
    output logic [4:0]      wb_addr
);

    always_comb begin
        wb_data = '0;
        case (wb_sel_e'(wb_sel))
            WB_ALU:  wb_data = alu_result;
            WB_MEM:  wb_data = mem_data;
            WB_LUI:  wb_data = lui_result;
            WB_LINK: wb_data = pc_plus4;
            default: wb_data = '0;
        endcase
    end

    // DST_NONE maps to register 0, which turns the commit into a no-write.
    always_comb begin
        wb_addr = REG_ZERO;
        case (dst_sel_e'(dst_sel))
            DST_RT:   wb_addr = rt;
            DST_RD:   wb_addr = rd;
            DST_RA:   wb_addr = REG_RA;
            DST_NONE: wb_addr = REG_ZERO;
            default:  wb_addr = REG_ZERO;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage plus 32-entry register file with two combinational read ports.
// Register 0 has no storage; register 29 resets to the initial stack pointer.
module writeback_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned      size    = 32,
    parameter logic [size-1:0]  sp_init = 32'h0000_3FFC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_write,
    input  logic [1:0]      wb_sel,
    input  logic [1:0]      dst_sel,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [size-1:0] alu_result,
    input  logic [size-1:0] mem_data,
    input  logic [size-1:0] lui_result,
    input  logic [size-1:0] pc_plus4,
    output logic [size-1:0] rs_data,
    output logic [size-1:0] rt_data,
    output logic [size-1:0] wb_data,
    output logic [4:0]      wb_addr
);

    logic [size-1:0] regs [1:31];
    logic            write_en;

    wb_mux #(
        .size(size)
    ) u_wb_mux (
        .wb_sel     (wb_sel),
        .dst_sel    (dst_sel),
        .rt         (rt),
        .rd         (rd),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .lui_result (lui_result),
        .pc_plus4   (pc_plus4),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr)
    );

    assign write_en = reg_write && (wb_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i] <= (5'(i) == REG_SP) ? sp_init : '0;
            end
        end else if (write_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // No write-to-read bypass: reads see state as of the last edge.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != REG_ZERO) rs_data = regs[rs];
        if (rt != REG_ZERO) rt_data = regs[rt];
    end

endmodule
